handshake_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready downstream sink between N valid/ready upstream masters, such as the team's incrementing-data masters. It locks a grant to one master for a bounded burst of beats, then rotates fairly. The data path is combinational through the granted port, and grant state is registered. It sits between the master bank and a single slave or consumer.

---
 rtl/handshake_rr_arbiter_if.sv | 28 ++
 rtl/handshake_rr_arbiter.sv | 116 +++++++++++
 tb/tb_handshake_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_rr_arbiter_if.sv
// rtl/handshake_rr_arbiter_if.sv - valid/ready bus bundle between the master bank, the arbiter and the sink
interface handshake_rr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       s_valid;
    logic [N*WIDTH-1:0] s_data;
    logic [N-1:0]       s_ready;
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic               m_ready;
    logic [N-1:0]       grant;
    logic [IDW-1:0]     grant_id;

    // Environment side: masters plus the downstream sink.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, grant, grant_id
    );

    // Arbiter side.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, grant, grant_id
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// rtl/handshake_rr_arbiter.sv - round-robin burst arbiter sharing one valid/ready sink among N masters
module handshake_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    handshake_rr_arbiter_if.slave bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           g_valid;
    logic           hs;
    logic           release_c;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] scan_base;
    logic           sel_found;
    logic [IDW-1:0] sel_idx;

    function automatic logic [IDW-1:0] wrap_add(logic [IDW-1:0] base, int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    assign g_valid   = bus.s_valid[gid_q];
    assign hs        = (state_q == GRANT) && g_valid && bus.m_ready;
    assign next_ptr  = (gid_q == IDW'(N - 1)) ? '0 : gid_q + 1'b1;
    assign release_c = (state_q == GRANT) && ((hs && (cnt_q == LAST_BEAT)) || !g_valid);

    // On release the scan starts just past the holder, so it is seen last and
    // only wins again when it is the sole requester.
    assign scan_base = (state_q == GRANT) ? next_ptr : ptr_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!sel_found && bus.s_valid[wrap_add(scan_base, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(scan_base, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gid_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    gid_d   = sel_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = next_ptr;
                    cnt_d = '0;
                    if (sel_found) begin
                        state_d = GRANT;
                        gid_d   = sel_idx;
                    end else begin
                        state_d = IDLE;
                        gid_d   = '0;
                    end
                end else if (hs) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.grant    = '0;
        bus.grant_id = gid_q;
        bus.m_valid  = 1'b0;
        bus.m_data   = '0;
        bus.s_ready  = '0;
        if (state_q == GRANT) begin
            bus.grant[gid_q]   = 1'b1;
            bus.m_valid        = g_valid;
            bus.m_data         = bus.s_data[int'(gid_q) * WIDTH +: WIDTH];
            bus.s_ready[gid_q] = bus.m_ready;
        end
    end
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb/tb_handshake_rr_arbiter.sv - scoreboard bench for handshake_rr_arbiter against a burst/rotation model
module tb_handshake_rr_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    handshake_rr_arbiter_if #(.WIDTH(W), .N(N)) bus ();
    handshake_rr_arbiter_if #(.WIDTH(W), .N(N)) bus1 ();

    handshake_rr_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    handshake_rr_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int gid;
        int gnt;
        int mv;
        int md;
        int sr;
    } exp_t;

    exp_t exp_q[$];
    int   beat_ids[$];
    int   pushed = 0;
    int   popped = 0;
    int   hs_seen = 0;

    // Reference model: who owns the sink, beats served in this burst, and
    // which master has top priority for the next selection.
    int owner;
    int prio;
    int beats;
    int seq[N];

    int  mb1_c0 = 0;
    int  mb1_c2 = 0;
    bit  mb1_on = 1'b0;

    function automatic int pick(int start, logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int word(int i);
        return i * 64 + seq[i] % 64;
    endfunction

    task automatic model_reset();
        owner = -1;
        prio  = 0;
        beats = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
    endtask

    task automatic cycle(logic [N-1:0] v, logic mr);
        exp_t             e;
        logic [N*W-1:0]   d;
        bit               hs;
        @(negedge clk);
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(word(i));
        bus.s_valid = v;
        bus.s_data  = d;
        bus.m_ready = mr;
        #1;
        e.gid = (owner < 0) ? 0 : owner;
        e.gnt = (owner < 0) ? 0 : (1 << owner);
        e.mv  = (owner < 0) ? 0 : int'(v[owner]);
        e.md  = (owner < 0) ? 0 : word(owner);
        e.sr  = (owner >= 0 && mr) ? (1 << owner) : 0;
        exp_q.push_back(e);
        pushed++;
        hs = (owner >= 0) && v[owner] && mr;
        if (owner < 0) begin
            owner = pick(prio, v);
            beats = 0;
        end else begin
            if (hs) begin
                seq[owner]++;
                beats++;
            end
            if (beats == MB || !v[owner]) begin
                prio  = (owner + 1) % N;
                beats = 0;
                owner = pick(prio, v);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_grant",    int'(bus.grant),    0);
        chk("rst_grant_id", int'(bus.grant_id), 0);
        chk("rst_m_valid",  int'(bus.m_valid),  0);
        chk("rst_m_data",   int'(bus.m_data),   0);
        chk("rst_s_ready",  int'(bus.s_ready),  0);
        chk("rst_mb1_valid", int'(bus1.m_valid), 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        bus.s_valid = '0;
        rst_n = 1'b1;
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                chk("grant_id", int'(bus.grant_id), e.gid);
                chk("grant",    int'(bus.grant),    e.gnt);
                chk("m_valid",  int'(bus.m_valid),  e.mv);
                chk("m_data",   int'(bus.m_data),   e.md);
                chk("s_ready",  int'(bus.s_ready),  e.sr);
                if (bus.m_valid && bus.m_ready) begin
                    hs_seen++;
                    beat_ids.push_back(int'(bus.grant_id));
                end
            end
        end
    end

    // MAX_BURST=1 instance: every beat must alternate between masters 0 and 2.
    initial begin : mon1
        int last;
        int expid;
        last = -1;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                last   = -1;
                mb1_c0 = 0;
                mb1_c2 = 0;
            end else if (mb1_on && bus1.m_valid && bus1.m_ready) begin
                expid = (last == 0) ? 2 : 0;
                chk("mb1_grant_id", int'(bus1.grant_id), expid);
                chk("mb1_m_data",   int'(bus1.m_data),   8'hA0 + expid);
                last = int'(bus1.grant_id);
                if (last == 0) mb1_c0++;
                else mb1_c2++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [N-1:0] v;
        int           base;
        int           d;
        bus.s_valid  = '0;
        bus.s_data   = '0;
        bus.m_ready  = 1'b0;
        bus1.s_valid = '0;
        bus1.s_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus1.m_ready = 1'b1;
        model_reset();

        do_reset();
        mb1_on       = 1'b1;
        bus1.s_valid = 4'b0101;
        repeat (10) cycle(4'b0000, 1'b1);

        do_reset();
        base = hs_seen;
        repeat (101) cycle(4'b0001, 1'b1);
        #2;
        chk("single_master_beats", hs_seen - base, 100);

        do_reset();
        beat_ids.delete();
        repeat (21) cycle(4'b1111, 1'b1);
        #2;
        chk("contention_beats", beat_ids.size(), 20);
        foreach (beat_ids[k]) chk("contention_order", beat_ids[k], (k / 4) % 4);

        do_reset();
        cycle(4'b0100, 1'b0);
        repeat (5) cycle(4'b0101, 1'b0);
        beat_ids.delete();
        repeat (6) cycle(4'b0101, 1'b1);
        #2;
        chk("backpressure_beats", beat_ids.size(), 6);
        if (beat_ids.size() > 0) chk("backpressure_master", beat_ids[0], 2);

        do_reset();
        cycle(4'b0010, 1'b1);
        cycle(4'b1010, 1'b1);
        cycle(4'b1010, 1'b1);
        cycle(4'b1000, 1'b1);
        repeat (3) cycle(4'b1000, 1'b1);
        cycle(4'b0101, 1'b1);
        repeat (4) cycle(4'b0111, 1'b1);

        do_reset();
        v = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) v[b] = ~v[b];
            cycle(v, $urandom_range(0, 3) != 0);
            if (i == 700) do_reset();
        end
        #2;

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("scoreboard_pops", popped, pushed);
        d = mb1_c0 - mb1_c2;
        chk("mb1_fairness", int'(d <= 1 && d >= -1), 1);
        chk("mb1_active", int'(mb1_c0 > 0 && mb1_c2 > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
